// File: rtl/mbus_master_req_sched_testbench.sv
// ---------------------------------------------------------------------------
// mbus_master_req_sched_testbench
//
// Round-robin scheduler that shares one MBus master node controller among
// NUM_REQ testbench message requesters. A granted requester has its bit
// threshold and idle policy latched onto NUM_BITS_THRESHOLD and
// FORCE_IDLE_WHEN_DONE. The scheduler then pulls the bus low (DOUT_REQ=0)
// to start a message, counts CIN falling edges while the message runs, and
// ends the message after CLK_IDLE_END consecutive CIN-high cycles. A quiet
// gap of IDLE_GAP cycles follows every message before the next grant.
//
// Optional feature macro: MBUSTB_SCHED_TIMEOUT_EN
//   defined   : START gives up after TIMEOUT_CYCLES cycles without a CIN
//               fall, pulses TIMEOUT and moves on to the quiet gap.
//   undefined : TIMEOUT is tied to 0 and START waits indefinitely.
//
// Ports
//   CLK_EXT               in   clock, all state on posedge
//   RESETn                in   synchronous active-low reset
//   CIN                   in   bus clock seen at the master node
//   DIN                   in   bus data seen at the master node (1 = bus free)
//   REQ[NUM_REQ]          in   per-requester message request (level)
//   THRESHOLD_IN          in   flattened thresholds, requester i in slice i
//   FORCE_IDLE_IN         in   per-requester FORCE_IDLE_WHEN_DONE value
//   GNT[NUM_REQ]          out  one-hot grant, registered
//   DOUT_REQ              out  start request into the bus, 0 = pull low
//   NUM_BITS_THRESHOLD    out  latched threshold of the granted requester
//   FORCE_IDLE_WHEN_DONE  out  latched idle policy of the granted requester
//   BIT_CNT[16]           out  CIN falls in current/last message, saturating
//   DONE                  out  one-cycle pulse at end of message
//   TIMEOUT               out  one-cycle pulse on START timeout
//   STATE_DBG[3]          out  current scheduler state, for observation only
//
// Request/grant handshake: REQ is a level that is sampled only while the
// scheduler is IDLE and the bus is free (DIN=1). GNT rises on the edge that
// accepts a request and stays high until the cycle DONE (or TIMEOUT) pulses.
// While GNT is high, REQ/THRESHOLD_IN/FORCE_IDLE_IN are ignored; a requester
// that keeps REQ high afterwards simply competes again in round-robin order.
// ---------------------------------------------------------------------------
`ifndef MBUSTB_BITS_WD_WIDTH
`define MBUSTB_BITS_WD_WIDTH 8
`endif

module mbus_master_req_sched_testbench #(
    parameter int NUM_REQ        = 4,
    parameter int CLK_IDLE_END   = 16,
    parameter int IDLE_GAP       = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                      CLK_EXT,
    input  logic                                      RESETn,
    input  logic                                      CIN,
    input  logic                                      DIN,
    input  logic [NUM_REQ-1:0]                        REQ,
    input  logic [NUM_REQ*`MBUSTB_BITS_WD_WIDTH-1:0]  THRESHOLD_IN,
    input  logic [NUM_REQ-1:0]                        FORCE_IDLE_IN,
    output logic [NUM_REQ-1:0]                        GNT,
    output logic                                      DOUT_REQ,
    output logic [`MBUSTB_BITS_WD_WIDTH-1:0]          NUM_BITS_THRESHOLD,
    output logic                                      FORCE_IDLE_WHEN_DONE,
    output logic [15:0]                               BIT_CNT,
    output logic                                      DONE,
    output logic                                      TIMEOUT,
    output logic [2:0]                                STATE_DBG
);

    localparam int BW  = `MBUSTB_BITS_WD_WIDTH;
    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int ICW = $clog2(CLK_IDLE_END + 1);
    localparam int GCW = $clog2(IDLE_GAP + 1);

    localparam logic [ICW-1:0]     IDLE_TERM = ICW'(CLK_IDLE_END - 1);
    localparam logic [GCW-1:0]     GAP_LOAD  = GCW'(IDLE_GAP - 1);
    localparam logic [IW-1:0]      LAST_RST  = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] GNT_ONE   = NUM_REQ'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_ACTIVE = 3'd2,
        S_DONE   = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic                 cin_prev;
    logic                 cin_fall;

    logic [IW-1:0]        last;
    logic [IW-1:0]        gnt_idx;
    logic                 win_found;
    logic [IW-1:0]        win_idx;
    int                   cand;
    logic [IW-1:0]        cand_idx;

    logic [BW-1:0]        thr_arr [NUM_REQ];

    logic [NUM_REQ-1:0]   gnt_q;
    logic [BW-1:0]        thr_q;
    logic                 fi_q;
    logic [15:0]          bit_cnt_q;
    logic [ICW-1:0]       idle_cnt;
    logic [GCW-1:0]       gap_cnt;
    logic                 tmo_hit;

    // -----------------------------------------------------------------------
    // CIN falling-edge detect
    // -----------------------------------------------------------------------
    assign cin_fall = cin_prev & ~CIN;

    // -----------------------------------------------------------------------
    // Unpack the per-requester threshold slices
    // -----------------------------------------------------------------------
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_thr
        assign thr_arr[g] = THRESHOLD_IN[g*BW +: BW];
    end

    // -----------------------------------------------------------------------
    // Round-robin pick: first set REQ bit scanning upward from last+1 with
    // wrap-around, so the most recently served requester has lowest priority.
    // -----------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand     = (int'(last) + k) % NUM_REQ;
            cand_idx = IW'(cand);
            if (!win_found && REQ[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Optional START timeout
    // -----------------------------------------------------------------------
`ifdef MBUSTB_SCHED_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] TMO_TERM = TCW'(TIMEOUT_CYCLES - 1);

    logic [TCW-1:0] tmo_cnt;
    logic           timeout_q;

    assign tmo_hit = (tmo_cnt == TMO_TERM);

    // The counter only runs inside START and is held at zero elsewhere, so
    // every grant starts a fresh timeout window.
    always_ff @(posedge CLK_EXT) begin
        if (!RESETn) begin
            tmo_cnt   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= (state == S_START) && (state_nxt == S_GAP);
            if (state != S_START) begin
                tmo_cnt <= '0;
            end else if (!tmo_hit) begin
                tmo_cnt <= tmo_cnt + TCW'(1);
            end
        end
    end

    assign TIMEOUT = timeout_q;
`else
    assign tmo_hit = 1'b0;
    assign TIMEOUT = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_EXT) begin
        if (!RESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // DIN low means another master owns the bus; hold off.
                if (win_found && DIN) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (cin_fall) begin
                    state_nxt = S_ACTIVE;
                end else if (tmo_hit) begin
                    state_nxt = S_GAP;
                end
            end
            S_ACTIVE: begin
                // A fall always restarts the idle window, so it beats the
                // terminal count when both would happen on the same edge.
                if (!cin_fall && CIN && (idle_cnt == IDLE_TERM)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_GAP;
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath: grant latch, bit counter, idle and gap counters
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK_EXT) begin
        cin_prev <= CIN;
        if (!RESETn) begin
            gnt_q     <= '0;
            gnt_idx   <= '0;
            last      <= LAST_RST;
            thr_q     <= '0;
            fi_q      <= 1'b0;
            bit_cnt_q <= '0;
            idle_cnt  <= '0;
            gap_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_START) begin
                        gnt_q     <= GNT_ONE << win_idx;
                        gnt_idx   <= win_idx;
                        thr_q     <= thr_arr[win_idx];
                        fi_q      <= FORCE_IDLE_IN[win_idx];
                        bit_cnt_q <= '0;
                        idle_cnt  <= '0;
                    end
                end
                S_START: begin
                    if (cin_fall) begin
                        bit_cnt_q <= 16'd1;
                        idle_cnt  <= '0;
                    end else if (state_nxt == S_GAP) begin
                        // Timed out: release the grant and skip DONE.
                        gnt_q   <= '0;
                        last    <= gnt_idx;
                        gap_cnt <= GAP_LOAD;
                    end
                end
                S_ACTIVE: begin
                    if (cin_fall) begin
                        if (bit_cnt_q != 16'hFFFF) begin
                            bit_cnt_q <= bit_cnt_q + 16'd1;
                        end
                        idle_cnt <= '0;
                    end else if (state_nxt == S_DONE) begin
                        // Drop GNT so it is already low in the DONE cycle.
                        gnt_q <= '0;
                        last  <= gnt_idx;
                    end else if (CIN) begin
                        idle_cnt <= idle_cnt + ICW'(1);
                    end
                end
                S_DONE: begin
                    gap_cnt <= GAP_LOAD;
                end
                S_GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - GCW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign GNT                  = gnt_q;
    assign DOUT_REQ             = (state != S_START);
    assign NUM_BITS_THRESHOLD   = thr_q;
    assign FORCE_IDLE_WHEN_DONE = fi_q;
    assign BIT_CNT              = bit_cnt_q;
    assign DONE                 = (state == S_DONE);
    assign STATE_DBG            = state;

endmodule

// File: doc/mbus_master_req_sched_testbench.md
# mbus_master_req_sched_testbench

Testbench-side round-robin scheduler that shares the MBus master node controller between up to NUM_REQ message requesters. It grants one requester at a time and loads that requester's bit threshold and idle-policy into the master node controller. It then pulls the bus low to start a message, counts clock edges on CIN while the message runs, and detects end-of-message from CIN idleness. It sits between the testbench message generators and the NUM_BITS_THRESHOLD / FORCE_IDLE_WHEN_DONE / DIN inputs of the master node controller.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- CLK_IDLE_END, 16, consecutive CIN-high cycles that mark end of message
- IDLE_GAP, 8, mandatory bus-quiet cycles between messages
- TIMEOUT_CYCLES, 64, START-phase timeout (only with MBUSTB_SCHED_TIMEOUT_EN)

Ports:
- CLK_EXT  in  1  clock, all state on posedge
- RESETn  in  1  reset; **one clock; reset is synchronous and active-low**
- CIN  in  1  bus clock observed at the master node
- DIN  in  1  bus data observed at the master node
- REQ  in  NUM_REQ  per-requester message request, level
- THRESHOLD_IN  in  NUM_REQ*`MBUSTB_BITS_WD_WIDTH  flattened per-requester thresholds; requester i occupies slice i
- FORCE_IDLE_IN  in  NUM_REQ  per-requester FORCE_IDLE_WHEN_DONE value
- GNT  out  NUM_REQ  one-hot grant, registered
- DOUT_REQ  out  1  start request driven into the bus; 0 means pull low
- NUM_BITS_THRESHOLD  out  `MBUSTB_BITS_WD_WIDTH  latched threshold of the granted requester
- FORCE_IDLE_WHEN_DONE  out  1  latched idle-policy of the granted requester
- BIT_CNT  out  16  CIN falling edges counted in the current or last message; saturates at 16'hFFFF
- DONE  out  1  one-cycle pulse at end of message
- TIMEOUT  out  1  one-cycle pulse on START timeout

## Operation
- **Edge detect:** cin_prev is registered every cycle. A fall is cin_prev & ~CIN.
- **Arbitration pointer:** `last` resets to NUM_REQ-1, so requester 0 wins first.
- **IDLE:**
  - DOUT_REQ=1 and GNT=0.
  - If any REQ is set and DIN==1, pick the first set index scanning from (last+1) mod NUM_REQ with wrap-around.
  - Register the winner's GNT bit, THRESHOLD_IN slice and FORCE_IDLE_IN bit.
  - Clear BIT_CNT and the timeout counter, then go to START.
- **START:**
  - DOUT_REQ=0.
  - On the first CIN fall: BIT_CNT=1, idle_cnt=0, go to ACTIVE.
- **ACTIVE:**
  - DOUT_REQ=1.
  - Each CIN fall increments BIT_CNT (saturating) and clears idle_cnt.
  - Otherwise, while CIN==1, idle_cnt increments.
  - When idle_cnt==CLK_IDLE_END-1 with CIN still high, go to DONE.
- **DONE:** single cycle.
  - DONE=1 and GNT=0; `last` is set to the granted index.
  - Load gap_cnt=IDLE_GAP-1 and go to GAP.
- **GAP:** decrement gap_cnt. At 0, go to IDLE.
- **While a grant is held:**
  - Changes to REQ, THRESHOLD_IN and FORCE_IDLE_IN are ignored; the transaction completes.
  - NUM_BITS_THRESHOLD and FORCE_IDLE_WHEN_DONE keep their latched values until the next grant.
- **Requester behaviour:** a requester holding REQ high after DONE is re-eligible, but round-robin order still applies.
- **Reset:**
  - Outputs are GNT=0, DOUT_REQ=1, NUM_BITS_THRESHOLD=0, FORCE_IDLE_WHEN_DONE=0, BIT_CNT=0, DONE=0, TIMEOUT=0.
  - State is IDLE with last=NUM_REQ-1.
  - Reset asserted mid-message takes effect at the next posedge; DOUT_REQ is released immediately after that edge.

## Timing
- REQ sampled in IDLE → GNT, DOUT_REQ=0 and latched outputs valid on the next posedge (1-cycle latency).
- First CIN fall at edge k → DOUT_REQ=1 from edge k+1.
- Last CIN fall at edge k → DONE high for edge k+CLK_IDLE_END only (idle_cnt reaches CLK_IDLE_END-1 at that edge).
- DONE → next possible GNT no earlier than IDLE_GAP+1 cycles later.
- A CIN fall in the same cycle idle_cnt would reach terminal count wins: the count restarts and there is no DONE.
- DIN==0 in IDLE (another master active) blocks a grant; REQ stays pending.

## Configuration
- **MBUSTB_SCHED_TIMEOUT_EN defined:**
  - In START, a counter increments each cycle.
  - At TIMEOUT_CYCLES-1 without a CIN fall: TIMEOUT=1 for one cycle, GNT=0, DOUT_REQ=1, `last` advances to the granted index, go to GAP. DONE is not pulsed.
- **Not defined:** no counter and no TIMEOUT logic. TIMEOUT is tied to 0 and START waits indefinitely.

## Test plan
- REQ=4'b0001, THRESHOLD_IN[0]=100, CIN toggles 40 falls after DOUT_REQ low → GNT=0001 next cycle, NUM_BITS_THRESHOLD=100, BIT_CNT=40, DONE 16 cycles after last fall.
- REQ=4'b1111 held across 5 messages → grant order 0,1,2,3,0, each grant at least 9 cycles after the previous DONE.
- REQ=4'b0100 with DIN held 0 for 30 cycles → no GNT until DIN=1; GNT=0100 one cycle after.
- CIN idle 15 cycles, then a fall, then idle 16 → no DONE after the first gap, DONE after the second.
- With MBUSTB_SCHED_TIMEOUT_EN, no CIN activity → TIMEOUT pulse 64 cycles into START, DOUT_REQ=1, DONE=0; without the macro, DOUT_REQ stays 0 indefinitely.
- RESETn=0 for 1 cycle mid-ACTIVE → all outputs at reset values after that edge; requester 0 wins the next grant.
